fanout_fork_ctrl: RTL and testbench
===================================

Name: fanout_fork_ctrl

Overview:
- Eager-fork controller that broadcasts one upstream stream token to up to NUM_OUT downstream consumers.
- Holds each token in a one-entry register and tracks which enabled consumers have already taken it.
- Releases the token only when every enabled consumer has accepted it.
- Sits between a stream producer (scanner, intersecter, reducer output) and the fanout ready-combine point. It replaces the purely combinational all-ready AND with per-consumer independent acceptance.

Parameters:
- NUM_OUT, 7, number of downstream consumers.
- DATA_W, 17, token width (16-bit payload + 1 control bit).
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; when 0, all state holds
- flush  in  1  synchronous clear of the token buffer, pending flags and stall counter; configuration is kept
- cfg_wr  in  1  write strobe for the consumer enable mask
- cfg_mask  in  NUM_OUT  new enable mask (bit i enables consumer i)
- cfg_err  out  1  one-cycle pulse when cfg_wr is rejected
- in_data  in  DATA_W  upstream token
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  DATA_W  broadcast token (shared by all consumers)
- out_valid  out  NUM_OUT  per-consumer valid
- out_ready  in  NUM_OUT  per-consumer ready
- busy  out  1  token buffer occupied
- stall_cnt  out  STALL_W  saturating count of blocked cycles

Behaviour:
- Reset (rst_n low, asynchronous): clear mask, full, pend, data register, stall_cnt and cfg_err.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
- State:
  - mask[NUM_OUT-1:0]: enable mask.
  - full: buffer-occupied flag.
  - pend[NUM_OUT-1:0]: consumers still owed the token.
  - data register.
- Per-consumer valid: out_valid[i] = full & pend[i]. out_data = data register.
- Per-consumer take: take[i] = out_valid[i] & out_ready[i].
- Release condition: last = full & ((pend & ~take) == 0).
- Upstream ready: in_ready = ~full | last. This is a combinational path from out_ready to in_ready, which is intended and allows full throughput.
- Accept: upstream handshake when in_valid & in_ready & clk_en.
  - On accept, load data, set full=1 and set pend=mask.
  - If mask==0: the token is dropped; full stays 0 and in_ready stays 1.
- Consumer take: when take[i] and clk_en, clear pend[i] next cycle.
- Release and accept in the same cycle: the new token loads pend=mask (new bits win over clears). There is no bubble between back-to-back tokens.
- Release without accept: full goes to 0.
- Consumers are independent: a consumer that has taken the token sees out_valid[i]=0 until the next token, even if it stays ready.
- Latency: token visible on out_data/out_valid one cycle after upstream accept.
- Throughput: one token per cycle when all enabled consumers are ready.
- stall_cnt: increments when clk_en & full & ~last. It saturates at all-ones and is cleared by flush or reset.
- Configuration:
  - cfg_wr with full=0 and no accept in the same cycle: mask=cfg_mask next cycle.
  - cfg_wr while full=1 or while an accept occurs: ignored, and cfg_err=1 for one cycle.
  - cfg_wr has priority over nothing else.
- Flush: has priority over accept, take and cfg_wr.
  - Next cycle: full=0, pend=0, stall_cnt=0, cfg_err=0; mask retained.
  - in_ready is forced to 0 during the flush cycle.
- clk_en=0: no register updates (including cfg and stall_cnt). in_ready/out_valid still reflect the held state; handshakes during clk_en=0 are not counted.
- Reset mid-token: the token is lost and all pend bits cleared immediately.

Test Plan:
- Mask=7'b0000101; in_valid with data 0x1A5; all out_ready=1 -> out_valid=0000101 next cycle, both take, in_ready=1 in that cycle, busy=0 after.
- Mask=0000111; ready 001 at t, 010 at t+1, 100 at t+2 -> out_valid goes 111, 110, 100, then 000. in_ready=1 only at t+2; stall_cnt=2.
- Mask=1111111; in_valid held high with 4 tokens; all ready -> 4 tokens delivered in 4 consecutive cycles, stall_cnt=0.
- Mask=0 -> every in_valid accepted immediately (in_ready=1), out_valid=0 throughout, busy=0.
- cfg_wr with cfg_mask=0000011 while full=1 -> cfg_err pulses for 1 cycle and mask is unchanged. Repeated after release -> accepted, no cfg_err.
- Token pending with pend=0000110, then flush=1 -> next cycle busy=0, out_valid=0, stall_cnt=0, mask kept.
- Separately, rst_n low mid-token -> outputs reset asynchronously without waiting for a clk edge.

Source files
------------

// File: rtl/fanout_fork_ctrl.sv
// Eager fork: buffers one upstream token and broadcasts it to every enabled
// consumer. Each consumer takes the token independently. The buffer is freed
// once the last owed consumer has taken it.
module fanout_fork_ctrl #(
    parameter int NUM_OUT = 7,
    parameter int DATA_W  = 17,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               cfg_wr,
    input  logic [NUM_OUT-1:0] cfg_mask,
    output logic               cfg_err,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [NUM_OUT-1:0] pend_q, pend_d;
    logic               full_q, full_d;
    logic               cfg_err_q, cfg_err_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [NUM_OUT-1:0] take;
    logic               last;
    logic               accept;

    // A consumer sees valid only while it is still owed the buffered token.
    assign out_valid = {NUM_OUT{full_q}} & pend_q;
    assign take      = out_valid & out_ready;
    // Last: every consumer still owed the token takes it this cycle.
    assign last      = full_q & ((pend_q & ~take) == '0);
    // Combinational out_ready -> in_ready path gives back-to-back tokens.
    assign in_ready  = ~flush & (~full_q | last);
    assign accept    = in_valid & in_ready & clk_en;

    assign out_data  = data_q;
    assign busy      = full_q;
    assign stall_cnt = stall_q;
    assign cfg_err   = cfg_err_q;

    // Next-state: flush beats everything; a new token's pend load beats clears.
    always_comb begin
        mask_d    = mask_q;
        pend_d    = pend_q;
        full_d    = full_q;
        cfg_err_d = cfg_err_q;
        data_d    = data_q;
        stall_d   = stall_q;
        if (clk_en) begin
            cfg_err_d = 1'b0;
            if (flush) begin
                full_d  = 1'b0;
                pend_d  = '0;
                stall_d = '0;
            end else begin
                pend_d = pend_q & ~take;
                if (last) begin
                    full_d = 1'b0;
                end
                // With an empty mask the token is swallowed and nothing loads.
                if (accept && (mask_q != '0)) begin
                    data_d = in_data;
                    full_d = 1'b1;
                    pend_d = mask_q;
                end
                if (full_q && !last && (stall_q != '1)) begin
                    stall_d = stall_q + 1'b1;
                end
                // Mask may only change while no token is buffered or arriving.
                if (cfg_wr) begin
                    if (full_q || accept) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        mask_d = cfg_mask;
                    end
                end
            end
        end
    end

    // State registers; reset drops any in-flight token immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            pend_q    <= '0;
            full_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            data_q    <= '0;
            stall_q   <= '0;
        end else begin
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            cfg_err_q <= cfg_err_d;
            data_q    <= data_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl: released tokens are checked against a
// queue of expected payloads, plus directed checks of valid/ready/stall/cfg.
module tb_fanout_fork_ctrl;

    localparam int NUM_OUT = 7;
    localparam int DATA_W  = 17;
    localparam int STALL_W = 16;

    logic               clk;
    logic               rst_n;
    logic               clk_en;
    logic               flush;
    logic               cfg_wr;
    logic [NUM_OUT-1:0] cfg_mask;
    logic               cfg_err;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic               busy;
    logic [STALL_W-1:0] stall_cnt;

    int vectors = 0;
    int errs    = 0;
    logic [DATA_W-1:0] sb_q[$];

    fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .cfg_wr    (cfg_wr),
        .cfg_mask  (cfg_mask),
        .cfg_err   (cfg_err),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at the negedge: a releasing token is popped from the scoreboard
    // and compared; then advance past the next posedge.
    task automatic tick();
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        if (clk_en && !flush && busy && in_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp = sb_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [NUM_OUT-1:0] m);
        cfg_wr   = 1'b1;
        cfg_mask = m;
        tick();
        cfg_wr   = 1'b0;
        #1;
        chk("cfg_ok_no_err", 32'(cfg_err), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        flush     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_mask  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        chk("rst_cfg_err",   32'(cfg_err),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two consumers, both ready: one-cycle delivery.
        cfg(7'b0000101);
        out_ready = '1;
        in_valid  = 1'b1;
        in_data   = 17'h1A5;
        sb_q.push_back(17'h1A5);
        #1;
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'b0000101);
        chk("t1_out_data",  32'(out_data),  32'h1A5);
        chk("t1_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Staggered acceptance across three consumers.
        cfg(7'b0000111);
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 17'h0F0;
        sb_q.push_back(17'h0F0);
        tick();
        in_valid  = 1'b0;
        out_ready = 7'b0000001;
        #1;
        chk("t2_v0", 32'(out_valid), 32'b0000111);
        chk("t2_r0", 32'(in_ready),  32'd0);
        tick();
        out_ready = 7'b0000010;
        #1;
        chk("t2_v1", 32'(out_valid), 32'b0000110);
        chk("t2_r1", 32'(in_ready),  32'd0);
        tick();
        out_ready = 7'b0000100;
        #1;
        chk("t2_v2", 32'(out_valid), 32'b0000100);
        chk("t2_r2", 32'(in_ready),  32'd1);
        tick();
        chk("t2_v3",    32'(out_valid), 32'd0);
        chk("t2_stall", 32'(stall_cnt), 32'd2);
        chk("t2_busy",  32'(busy),      32'd0);

        // Flush clears the stall counter; then full-throughput streaming.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t3_stall_clr", 32'(stall_cnt), 32'd0);
        cfg(7'b1111111);
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 17'h100 + 17'(k);
            sb_q.push_back(17'h100 + 17'(k));
            #1;
            chk("t3_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("t3_out_valid", 32'(out_valid), 32'h7F);
        end
        in_valid = 1'b0;
        #1;
        chk("t3_last_data", 32'(out_data), 32'h103);
        tick();
        chk("t3_busy",  32'(busy),      32'd0);
        chk("t3_stall", 32'(stall_cnt), 32'd0);

        // Empty mask: tokens are swallowed.
        cfg(7'b0000000);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 17'h55 + 17'(k);
            #1;
            chk("t4_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("t4_out_valid", 32'(out_valid), 32'd0);
            chk("t4_busy",      32'(busy),      32'd0);
        end
        in_valid = 1'b0;

        // Config write rejected while full; accepted after release.
        cfg(7'b0000101);
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 17'h1234;
        sb_q.push_back(17'h1234);
        tick();
        in_valid = 1'b0;
        cfg_wr   = 1'b1;
        cfg_mask = 7'b0000011;
        tick();
        cfg_wr = 1'b0;
        #1;
        chk("t5_cfg_err", 32'(cfg_err), 32'd1);
        tick();
        chk("t5_cfg_err_pulse", 32'(cfg_err), 32'd0);
        out_ready = '1;
        tick();
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 17'h0321;
        sb_q.push_back(17'h0321);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_mask_kept", 32'(out_valid), 32'b0000101);
        out_ready = '1;
        tick();
        out_ready = '0;
        cfg(7'b0000011);
        in_valid = 1'b1;
        in_data  = 17'h0777;
        sb_q.push_back(17'h0777);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_mask_new", 32'(out_valid), 32'b0000011);
        out_ready = '1;
        tick();
        out_ready = '0;

        // Flush with pend=0000110; mask must survive.
        cfg(7'b0000111);
        in_valid = 1'b1;
        in_data  = 17'h0BEE;
        tick();
        in_valid  = 1'b0;
        out_ready = 7'b0000001;
        tick();
        out_ready = '0;
        #1;
        chk("t6_pend", 32'(out_valid), 32'b0000110);
        flush = 1'b1;
        #1;
        chk("t6_flush_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_stall", 32'(stall_cnt), 32'd0);
        in_valid = 1'b1;
        in_data  = 17'h00AA;
        sb_q.push_back(17'h00AA);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_mask_kept", 32'(out_valid), 32'b0000111);

        // Clock enable low: ready consumers cannot take the token.
        clk_en    = 1'b0;
        out_ready = '1;
        tick();
        chk("t7_hold_valid", 32'(out_valid), 32'b0000111);
        chk("t7_hold_busy",  32'(busy),      32'd1);
        clk_en = 1'b1;
        tick();
        out_ready = '0;
        chk("t7_released", 32'(busy), 32'd0);

        // Asynchronous reset mid-token.
        in_valid = 1'b1;
        in_data  = 17'h03C3;
        tick();
        in_valid = 1'b0;
        chk("t8_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_busy",     32'(busy),      32'd0);
        chk("t8_valid",    32'(out_valid), 32'd0);
        chk("t8_data",     32'(out_data),  32'd0);
        chk("t8_in_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
